// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for one sram1024x18 macro: port A writes, port B reads, and a
// two-slot prefetch buffer gives the consumer a first-word-fall-through view.
module sram_fifo_ctrl #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              sram_cen_a,
  output logic              sram_wen_a,
  output logic [ADDR_W-1:0] sram_addr_a,
  output logic [DATA_W-1:0] sram_wmsk_a,
  output logic [DATA_W-1:0] sram_wdata_a,
  output logic              sram_cen_b,
  output logic              sram_wen_b,
  output logic [ADDR_W-1:0] sram_addr_b,
  output logic [DATA_W-1:0] sram_wmsk_b,
  output logic [DATA_W-1:0] sram_wdata_b,
  input  logic [DATA_W-1:0] sram_rdata_b
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   sram_occ;
  logic              rd_inflight;
  logic [1:0]        buf_cnt;
  logic [1:0]        buf_after_pop;
  logic [2:0]        committed;
  logic [DATA_W-1:0] buf_head;
  logic [DATA_W-1:0] buf_skid;
  logic              push_fire;
  logic              pop_fire;
  logic              rd_issue;

  assign sram_occ   = wr_ptr - rd_ptr;
  assign full       = (count == DEPTH);
  assign empty      = (count == '0);
  assign push_ready = !full && !rst;
  assign push_fire  = push_valid && push_ready;
  assign pop_valid  = (buf_cnt != 2'd0);
  assign pop_fire   = pop_valid && pop_ready;
  assign pop_data   = buf_head;

  // Slots already spoken for once this cycle's pop leaves; a read may only be
  // issued if its return is guaranteed a free slot.
  assign buf_after_pop = buf_cnt - {1'b0, pop_fire};
  assign committed     = {1'b0, buf_after_pop} + {2'b00, rd_inflight};
  assign rd_issue      = !rst && (sram_occ != '0) && (committed < 3'd2);

  assign sram_cen_a   = !push_fire;
  assign sram_wen_a   = !push_fire;
  assign sram_addr_a  = wr_ptr[ADDR_W-1:0];
  assign sram_wmsk_a  = '0;
  assign sram_wdata_a = push_data;
  assign sram_cen_b   = !rd_issue;
  assign sram_wen_b   = 1'b1;
  assign sram_addr_b  = rd_ptr[ADDR_W-1:0];
  assign sram_wmsk_b  = '1;
  assign sram_wdata_b = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      buf_cnt     <= 2'd0;
      buf_head    <= '0;
      buf_skid    <= '0;
      count       <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_issue)  rd_ptr <= rd_ptr + PTR_ONE;
      rd_inflight <= rd_issue;

      if (pop_fire) buf_head <= buf_skid;
      // A return lands in the lowest slot left free after the pop; it overrides the shift.
      if (rd_inflight) begin
        if (buf_after_pop == 2'd0) buf_head <= sram_rdata_b;
        else                       buf_skid <= sram_rdata_b;
      end
      buf_cnt <= buf_after_pop + {1'b0, rd_inflight};

      case ({push_fire, pop_fire})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural sram1024x18 model and a
// queue scoreboard fed on accepted pushes and drained on accepted pops.
module tb_sram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [17:0] push_data = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [17:0] pop_data;
  logic [10:0] count;
  logic        full, empty;
  logic        sram_cen_a, sram_wen_a, sram_cen_b, sram_wen_b;
  logic [9:0]  sram_addr_a, sram_addr_b;
  logic [17:0] sram_wmsk_a, sram_wdata_a, sram_wmsk_b, sram_wdata_b;
  logic [17:0] sram_rdata_b = '0;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int wr0_hits = 0;
  logic [17:0] sb_q[$];
  logic [17:0] mem [0:1023];

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .full(full), .empty(empty),
    .sram_cen_a(sram_cen_a), .sram_wen_a(sram_wen_a), .sram_addr_a(sram_addr_a),
    .sram_wmsk_a(sram_wmsk_a), .sram_wdata_a(sram_wdata_a),
    .sram_cen_b(sram_cen_b), .sram_wen_b(sram_wen_b), .sram_addr_b(sram_addr_b),
    .sram_wmsk_b(sram_wmsk_b), .sram_wdata_b(sram_wdata_b),
    .sram_rdata_b(sram_rdata_b)
  );

  // Macro model: inputs latched at the edge, write/read visible the next cycle.
  always @(posedge clk) begin
    if (!sram_cen_a && !sram_wen_a) mem[sram_addr_a] <= sram_wdata_a;
    if (!sram_cen_b) sram_rdata_b <= mem[sram_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard feed: every accepted push becomes an expected pop.
  always @(negedge clk) begin
    if (rst) sb_q.delete();
    else if (push_valid && push_ready) begin
      sb_q.push_back(push_data);
      if (sram_addr_a == 10'd0) wr0_hits++;
    end
  end

  // Monitor: occupancy bookkeeping and in-order pop comparison.
  always @(negedge clk) begin
    if (rst) exp_cnt = 0;
    else begin
      check("count", 32'(count), 32'(exp_cnt));
      check("full_flag", 32'(full), 32'(exp_cnt == 1024));
      check("empty_flag", 32'(empty), 32'(exp_cnt == 0));
      if (pop_valid && pop_ready) begin
        if (sb_q.size() == 0) check("pop_unexpected", 32'(pop_data), 32'h7FFFFFFF);
        else check("pop_data", 32'(pop_data), 32'(sb_q.pop_front()));
      end
      exp_cnt = exp_cnt + int'(push_valid && push_ready) - int'(pop_valid && pop_ready);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    @(negedge clk);
    while (!empty && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(empty), 32'd1);
    check({name, "_sb"}, 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
    pop_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, cyc, wr0_start, n;

    // Reset held with a push pending: nothing may be accepted or written.
    push_valid = 1'b1;
    push_data  = 18'h3FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("rst_push_ready", 32'(push_ready), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_pop_data", 32'(pop_data), 32'd0);
        check("rst_cen_a", 32'(sram_cen_a), 32'd1);
        check("rst_wen_a", 32'(sram_wen_a), 32'd1);
        check("rst_cen_b", 32'(sram_cen_b), 32'd1);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    push_valid = 1'b0;
    @(negedge clk);
    check("post_rst_push_ready", 32'(push_ready), 32'd1);
    @(posedge clk); #1;

    // Latency: push at edge N, visible after edge N+2.
    push_valid = 1'b1;
    push_data  = 18'h2A5A5;
    step();
    push_valid = 1'b0;
    @(negedge clk);
    check("lat_n0_pop_valid", 32'(pop_valid), 32'd0);
    step();
    @(negedge clk);
    check("lat_n1_pop_valid", 32'(pop_valid), 32'd0);
    step();
    @(negedge clk);
    check("lat_n2_pop_valid", 32'(pop_valid), 32'd1);
    check("lat_n2_pop_data", 32'(pop_data), 32'h2A5A5);
    check("lat_count", 32'(count), 32'd1);
    @(posedge clk); #1;
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    @(negedge clk);
    check("lat_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;

    // Fill to capacity with pop_ready low.
    for (int i = 0; i < 1024; i++) begin
      push_valid = 1'b1;
      push_data  = 18'(i);
      step();
    end
    push_data = 18'h15555;
    @(negedge clk);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd1024);
    check("fill_push_ready", 32'(push_ready), 32'd0);
    @(posedge clk); #1;

    // Full boundary: pop accepted, push refused in the same cycle.
    pop_ready = 1'b1;
    @(negedge clk);
    check("bnd_push_ready", 32'(push_ready), 32'd0);
    check("bnd_pop_valid", 32'(pop_valid), 32'd1);
    @(posedge clk); #1;
    pop_ready = 1'b0;
    @(negedge clk);
    check("bnd_count_1023", 32'(count), 32'd1023);
    check("bnd_push_ready_next", 32'(push_ready), 32'd1);
    @(posedge clk); #1;
    push_valid = 1'b0;
    @(negedge clk);
    check("bnd_count_1024", 32'(count), 32'd1024);
    @(posedge clk); #1;
    drain("fill_drain_empty");

    // Random streaming across several address wraps.
    wr0_start = wr0_hits;
    sent = 0;
    cyc  = 0;
    while (sent < 3000 && cyc < 20000) begin
      push_valid = 1'($urandom_range(0, 1));
      push_data  = 18'(sent + 100);
      pop_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (push_valid && push_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    check("wrap_sent", 32'(sent), 32'd3000);
    check("wrap_addr0_twice", 32'(wr0_hits - wr0_start >= 2), 32'd1);
    drain("wrap_drain_empty");

    // Reset mid-stream with a read in flight.
    for (int i = 0; i < 500; i++) begin
      push_valid = 1'b1;
      push_data  = 18'(i + 7000);
      step();
    end
    push_valid = 1'b0;
    step();
    step();
    step();
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_pop_valid", 32'(pop_valid), 32'd0);
    @(posedge clk); #1;
    push_valid = 1'b1;
    push_data  = 18'h00001;
    step();
    push_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!pop_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_pop_valid_after", 32'(pop_valid), 32'd1);
    check("mid_rst_pop_data", 32'(pop_data), 32'h00001);
    @(posedge clk); #1;
    drain("mid_rst_drain_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
